// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL lock sequencer.
//   seq_state_e : sequencer state encoding
//   RELOCK_W    : width of the relock event counter
//   sat_inc     : saturating increment for the relock counter
package pll_seq_pkg;

  typedef enum logic [1:0] {
    PLLRST    = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } seq_state_e;

  localparam int unsigned RELOCK_W = 32'd8;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [RELOCK_W-1:0] sat_inc(input logic [RELOCK_W-1:0] value);
    if (value == {RELOCK_W{1'b1}}) begin
      sat_inc = value;
    end else begin
      sat_inc = value + RELOCK_W'(1);
    end
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// PLL-side and reset-side signals of the lock sequencer.
//   pll_extlock  : PLL lock indication, asynchronous to refclk
//   force_relock : single-cycle request to restart the PLL sequence
//   pll_reset    : PLL reset pin, active-high
//   sys_rst      : system reset, active-high
//   locked       : high only while running
//   timeout_err  : one-cycle pulse on lock timeout
//   relock_count : saturating count of exits from RUN
// master = the sequencer, slave = the PLL/reset environment.
interface pll_lock_sequencer_if;
  import pll_seq_pkg::*;

  logic                pll_extlock;
  logic                force_relock;
  logic                pll_reset;
  logic                sys_rst;
  logic                locked;
  logic                timeout_err;
  logic [RELOCK_W-1:0] relock_count;

  modport master (
    input  pll_extlock, force_relock,
    output pll_reset, sys_rst, locked, timeout_err, relock_count
  );

  modport slave (
    output pll_extlock, force_relock,
    input  pll_reset, sys_rst, locked, timeout_err, relock_count
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit.
//   clk   : destination clock
//   reset : synchronous, active-high; clears both flops to 0
//   d     : asynchronous input
//   q     : synchronised output, two destination edges behind d
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic q_r;

  // Metastability chain: first flop may go metastable, second resolves it.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_r <= 1'b0;
      q_r    <= 1'b0;
    end else begin
      meta_r <= d;
      q_r    <= meta_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Sequences PLL reset and lock qualification on the board reference clock
// and produces the design-wide system reset.
//   refclk : board reference clock, sole clock of this block
//   reset  : synchronous, active-high
//   bus    : pll_lock_sequencer_if.master (extlock/force in, PLL reset,
//            sys_rst, locked, timeout_err, relock_count out)
// sys_rst is released only after lock has been stable for LOCK_STABLE
// cycles and RST_HOLD further cycles have elapsed in RUN. Lock loss in RUN,
// a lock timeout or a force request re-runs the PLL reset sequence.
module pll_lock_sequencer #(
  parameter int unsigned PLL_RST_CYCLES = 32'd48,
  parameter int unsigned LOCK_TIMEOUT   = 32'd24000,
  parameter int unsigned LOCK_STABLE    = 32'd1024,
  parameter int unsigned RST_HOLD       = 32'd16,
  parameter int unsigned CNT_W          = 32'd16
) (
  input  logic                 refclk,
  input  logic                 reset,
  pll_lock_sequencer_if.master bus
);
  import pll_seq_pkg::*;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 32'd1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 32'd1);
  localparam logic [CNT_W-1:0] HOLD_SAT    = CNT_W'(RST_HOLD);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic                lock_s;
  seq_state_e          state_r;
  seq_state_e          state_n_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [CNT_W-1:0]    cnt_n_s;
  logic                timeout_s;
  logic                leave_run_s;

  logic                pll_reset_r;
  logic                sys_rst_r;
  logic                locked_r;
  logic                timeout_err_r;
  logic [RELOCK_W-1:0] relock_count_r;

  sync_2ff u_lock_sync (
    .clk   (refclk),
    .reset (reset),
    .d     (bus.pll_extlock),
    .q     (lock_s)
  );

  // The timeout pulse is raised even when a force request overrides the move.
  assign timeout_s   = (state_r == WAIT_LOCK) && !lock_s && (cnt_r == TIMEOUT_LAST);
  // Lock loss and force in the same cycle count as a single exit from RUN.
  assign leave_run_s = (state_r == RUN) && (bus.force_relock || !lock_s);

  // Next-state and shared-counter decode; force_relock overrides everything.
  always_comb begin
    state_n_s = state_r;
    cnt_n_s   = cnt_r;
    if (bus.force_relock) begin
      state_n_s = PLLRST;
      cnt_n_s   = '0;
    end else begin
      case (state_r)
        PLLRST: begin
          if (cnt_r == RST_LAST) begin
            state_n_s = WAIT_LOCK;
            cnt_n_s   = '0;
          end else begin
            cnt_n_s = cnt_r + CNT_ONE;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_n_s = STABLE;
            cnt_n_s   = '0;
          end else if (cnt_r == TIMEOUT_LAST) begin
            state_n_s = PLLRST;
            cnt_n_s   = '0;
          end else begin
            cnt_n_s = cnt_r + CNT_ONE;
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state_n_s = WAIT_LOCK;
            cnt_n_s   = '0;
          end else if (cnt_r == STABLE_LAST) begin
            state_n_s = RUN;
            cnt_n_s   = '0;
          end else begin
            cnt_n_s = cnt_r + CNT_ONE;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_n_s = PLLRST;
            cnt_n_s   = '0;
          end else if (cnt_r >= HOLD_SAT) begin
            cnt_n_s = HOLD_SAT;
          end else begin
            cnt_n_s = cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_n_s = PLLRST;
          cnt_n_s   = '0;
        end
      endcase
    end
  end

  // Sequencer state, counter and registered outputs derived from the next state.
  always_ff @(posedge refclk) begin
    if (reset) begin
      state_r        <= PLLRST;
      cnt_r          <= '0;
      pll_reset_r    <= 1'b1;
      sys_rst_r      <= 1'b1;
      locked_r       <= 1'b0;
      timeout_err_r  <= 1'b0;
      relock_count_r <= '0;
    end else begin
      state_r       <= state_n_s;
      cnt_r         <= cnt_n_s;
      pll_reset_r   <= (state_n_s == PLLRST);
      locked_r      <= (state_n_s == RUN);
      sys_rst_r     <= !((state_n_s == RUN) && (cnt_n_s >= HOLD_SAT));
      timeout_err_r <= timeout_s;
      if (leave_run_s) begin
        relock_count_r <= sat_inc(relock_count_r);
      end else begin
        relock_count_r <= relock_count_r;
      end
    end
  end

  assign bus.pll_reset    = pll_reset_r;
  assign bus.sys_rst      = sys_rst_r;
  assign bus.locked       = locked_r;
  assign bus.timeout_err  = timeout_err_r;
  assign bus.relock_count = relock_count_r;

endmodule
